seg_scan_capture: RTL

- Receiving end of the multiplexed 7-segment display bus (SegsChose/SegsValue) that the clock top drives.
- Samples the scanned digits, waits for each one to settle and decodes it back to a 4-bit code.
- Assembles a full 8-digit frame and publishes it with a valid pulse.
- Used as an on-chip display monitor and as the self-checking front end of clock benches.

---
 rtl/seg_scan_pkg.sv | 67 ++++++
 rtl/seg_scan_capture_decode.sv | 32 +++
 rtl/seg_scan_capture.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the 7-segment scan capture block:
//   - normalised segment patterns SEG_0..SEG_9, ordered {a,b,c,d,e,f,g},
//     where 1 means the segment is lit
//   - decode result codes for a blank digit and an unrecognised pattern
//   - the capture FSM state type
//   - small helpers that classify the digit-select vector and scan a frame
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    localparam logic [3:0]  CODE_BLANK   = 4'hF;
    localparam logic [3:0]  CODE_INVALID = 4'hE;
    localparam logic [31:0] FRAME_BLANK  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Number of active digit-select lines (0 = gap, 1 = digit, >1 = error).
    function automatic logic [3:0] sel_count(input logic [7:0] sel);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'b000, sel[k]};
        end
        return n;
    endfunction

    // Position of the active select line; only meaningful for one-hot input.
    function automatic logic [2:0] sel_index(input logic [7:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (sel[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

    // True when any nibble of a frame is the invalid-pattern code.
    function automatic logic has_invalid(input logic [31:0] frame);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (frame[4*k +: 4] == CODE_INVALID) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/seg_scan_capture_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational 7-segment to 4-bit code decoder.
//   i_seg  [6:0] : normalised segment pattern {a,b,c,d,e,f,g}, 1 = lit
//   o_code [3:0] : 0..9 for a recognised digit, F for all-off, E otherwise
// -----------------------------------------------------------------------------
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code
);

    always_comb begin
        o_code = CODE_INVALID;
        case (i_seg)
            SEG_0:   o_code = 4'h0;
            SEG_1:   o_code = 4'h1;
            SEG_2:   o_code = 4'h2;
            SEG_3:   o_code = 4'h3;
            SEG_4:   o_code = 4'h4;
            SEG_5:   o_code = 4'h5;
            SEG_6:   o_code = 4'h6;
            SEG_7:   o_code = 4'h7;
            SEG_8:   o_code = 4'h8;
            SEG_9:   o_code = 4'h9;
            7'h00:   o_code = CODE_BLANK;
            default: o_code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
// Receives a multiplexed 8-digit 7-segment bus, debounces each scanned digit,
// decodes it and publishes complete frames.
//
// Ports:
//   Clk           system clock
//   RST           synchronous reset, active high
//   EN            capture enable; low freezes the sample pipeline and the FSM
//   SegsChose[7:0] digit select, bit i selects digit i (digit 0 rightmost)
//   SegsValue[6:0] segment lines {a,b,c,d,e,f,g}
//   Digits[31:0]  last committed frame, nibble i = digit i
//   FrameValid    one-cycle pulse when Digits is written
//   FrameChanged  one-cycle pulse with FrameValid when the frame differs
//   FrameErr      one-cycle pulse on ordering/select error or watchdog expiry
//   BadDigit      high while the committed frame holds an invalid (E) nibble
//
// Optional build macro SEG_CAPTURE_TIMEOUT_EN: adds a watchdog that abandons a
// partially collected frame after TIMEOUT_CYCLES enabled cycles without an
// accepted digit, blanking Digits.
// -----------------------------------------------------------------------------
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        Clk,
    input  logic        RST,
    input  logic        EN,
    input  logic [7:0]  SegsChose,
    input  logic [6:0]  SegsValue,
    output logic [31:0] Digits,
    output logic        FrameValid,
    output logic        FrameChanged,
    output logic        FrameErr,
    output logic        BadDigit
);

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    // Normalised sample (1 = active) and the sample before it.
    logic [7:0]       r_sel;
    logic [6:0]       r_seg;
    logic [7:0]       r_prev_sel;
    logic [6:0]       r_prev_seg;
    logic [7:0]       r_cnt;

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [7:0][3:0]  r_shadow;
    logic [31:0]      r_digits;
    logic             r_frame_valid;
    logic             r_frame_changed;
    logic             r_frame_err;
    logic             r_bad_digit;

    logic             w_same;
    logic [7:0]       w_cnt_next;
    logic             w_settled;
    logic [3:0]       w_sel_n;
    logic [2:0]       w_idx;
    logic [3:0]       w_code;
    logic             w_accept;
    logic             w_sel_err;

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_sel      <= '0;
            r_seg      <= '0;
            r_prev_sel <= '0;
            r_prev_seg <= '0;
            r_cnt      <= '0;
        end else if (EN) begin
            r_sel      <= (SEL_ACTIVE_LOW != 0) ? ~SegsChose : SegsChose;
            r_seg      <= (SEG_ACTIVE_LOW != 0) ? ~SegsValue : SegsValue;
            r_prev_sel <= r_sel;
            r_prev_seg <= r_seg;
            r_cnt      <= w_cnt_next;
        end
    end

    assign w_same     = ({r_sel, r_seg} == {r_prev_sel, r_prev_seg});
    assign w_cnt_next = !w_same ? 8'd1 : ((r_cnt == SETTLE) ? r_cnt : r_cnt + 8'd1);
    // Fires only on the arrival at SETTLE; a saturated counter holding the
    // same sample does not fire again. A change reloading straight to
    // SETTLE (SETTLE_CYCLES == 1) counts as a new arrival.
    assign w_settled  = (w_cnt_next == SETTLE) && (!w_same || (r_cnt != SETTLE));
    assign w_sel_n    = sel_count(r_sel);
    assign w_idx      = sel_index(r_sel);
    assign w_accept   = EN && w_settled && (w_sel_n == 4'd1);
    // One error per distinct multi-select pattern, not one per cycle.
    assign w_sel_err  = EN && !w_same && (w_sel_n > 4'd1);

    seg7_decode u_decode (
        .i_seg  (r_seg),
        .o_code (w_code)
    );

`ifdef SEG_CAPTURE_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_wd;
    logic        w_timeout;

    assign w_timeout = (r_state == COLLECT) && (r_wd == WD_LAST);

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_wd <= '0;
        end else if (EN) begin
            if ((r_state != COLLECT) || w_accept || w_sel_err || w_timeout) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + 32'd1;
            end
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_state         <= SYNC;
            r_idx           <= 3'd0;
            r_shadow        <= FRAME_BLANK;
            r_digits        <= FRAME_BLANK;
            r_frame_valid   <= 1'b0;
            r_frame_changed <= 1'b0;
            r_frame_err     <= 1'b0;
            r_bad_digit     <= 1'b0;
        end else begin
            r_frame_valid   <= 1'b0;
            r_frame_changed <= 1'b0;
            r_frame_err     <= 1'b0;
            if (EN) begin
                // The commit always lands; events seen in the same cycle are
                // handled below as if already back in COLLECT with idx 0.
                if (r_state == COMMIT) begin
                    r_digits        <= r_shadow;
                    r_frame_valid   <= 1'b1;
                    r_frame_changed <= (r_shadow != r_digits);
                    r_bad_digit     <= has_invalid(r_shadow);
                end
                if (w_sel_err) begin
                    r_frame_err <= 1'b1;
                    r_state     <= SYNC;
                    r_idx       <= 3'd0;
                    r_shadow    <= FRAME_BLANK;
                end else if (w_accept) begin
                    if (r_state == SYNC) begin
                        if (w_idx == 3'd0) begin
                            r_shadow <= {28'hFFF_FFFF, w_code};
                            r_idx    <= 3'd1;
                            r_state  <= COLLECT;
                        end
                    end else if (w_idx == r_idx) begin
                        r_shadow[r_idx] <= w_code;
                        if (r_idx == 3'd7) begin
                            r_idx   <= 3'd0;
                            r_state <= COMMIT;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= COLLECT;
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        // An out-of-order digit 0 is itself a valid frame start.
                        if (w_idx == 3'd0) begin
                            r_shadow <= {28'hFFF_FFFF, w_code};
                            r_idx    <= 3'd1;
                            r_state  <= COLLECT;
                        end else begin
                            r_shadow <= FRAME_BLANK;
                            r_idx    <= 3'd0;
                            r_state  <= SYNC;
                        end
                    end
                end else if (r_state == COMMIT) begin
                    r_state <= COLLECT;
`ifdef SEG_CAPTURE_TIMEOUT_EN
                end else if (w_timeout) begin
                    r_frame_err     <= 1'b1;
                    r_state         <= SYNC;
                    r_idx           <= 3'd0;
                    r_shadow        <= FRAME_BLANK;
                    r_digits        <= FRAME_BLANK;
                    r_frame_valid   <= 1'b1;
                    r_frame_changed <= (r_digits != FRAME_BLANK);
                    r_bad_digit     <= 1'b0;
`endif
                end
            end
        end
    end

    assign Digits       = r_digits;
    assign FrameValid   = r_frame_valid;
    assign FrameChanged = r_frame_changed;
    assign FrameErr     = r_frame_err;
    assign BadDigit     = r_bad_digit;

endmodule
